// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: widths, stage indices,
// trap CSR addresses and the trap-sequencer state encoding.
package pipe_ctrl_pkg;

  localparam int REG_W   = 32;
  localparam int CSR_AW  = 12;
  localparam int STAGE_W = 5;

  localparam int STAGE_PC    = 0;
  localparam int STAGE_IF_ID = 1;
  localparam int STAGE_ID_EX = 2;
  localparam int STAGE_EX_LS = 3;
  localparam int STAGE_LS_WB = 4;

  localparam logic [CSR_AW-1:0] CSR_MEPC   = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE = 12'h342;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T_MEPC  = 3'd1,
    T_CAUSE = 3'd2,
    T_JUMP  = 3'd3,
    R_JUMP  = 3'd4
  } trap_state_e;

  // Hold mask covering every pipeline register from PC up to and including idx.
  function automatic logic [STAGE_W-1:0] hold_upto(input int idx);
    logic [STAGE_W-1:0] m;
    for (int i = 0; i < STAGE_W; i++) m[i] = (i <= idx);
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the stage units/ifu (master) and the pipeline controller (slave).
// Handshake: there is no valid/ready pair here; jump_req_o and csr_we_o are
// single-cycle strobes without back-pressure, and stall_o/flush_o are the only flow control.
interface pipe_ctrl_if import pipe_ctrl_pkg::*;;

  logic               id_stallreq_i;
  logic               ex_stallreq_i;
  logic               ls_stallreq_i;
  logic               id_jump_req_i;
  logic [REG_W-1:0]   id_jump_pc_i;
  logic [REG_W-1:0]   id_pc_i;
  logic               id_ecall_i;
  logic               id_ebreak_i;
  logic               id_mret_i;
  logic [REG_W-1:0]   csr_mtvec_i;
  logic [REG_W-1:0]   csr_mepc_i;

  logic [STAGE_W-1:0] stall_o;
  logic [STAGE_W-1:0] flush_o;
  logic               jump_req_o;
  logic [REG_W-1:0]   jump_pc_o;
  logic               csr_we_o;
  logic [CSR_AW-1:0]  csr_waddr_o;
  logic [REG_W-1:0]   csr_wdata_o;
  logic               trap_busy_o;
  trap_state_e        trap_state;

  modport master (
    output id_stallreq_i, ex_stallreq_i, ls_stallreq_i, id_jump_req_i, id_jump_pc_i,
           id_pc_i, id_ecall_i, id_ebreak_i, id_mret_i, csr_mtvec_i, csr_mepc_i,
    input  stall_o, flush_o, jump_req_o, jump_pc_o, csr_we_o, csr_waddr_o,
           csr_wdata_o, trap_busy_o, trap_state
  );

  modport slave (
    input  id_stallreq_i, ex_stallreq_i, ls_stallreq_i, id_jump_req_i, id_jump_pc_i,
           id_pc_i, id_ecall_i, id_ebreak_i, id_mret_i, csr_mtvec_i, csr_mepc_i,
    output stall_o, flush_o, jump_req_o, jump_pc_o, csr_we_o, csr_waddr_o,
           csr_wdata_o, trap_busy_o, trap_state
  );

endinterface

// File: rtl/pipe_ctrl_stall_arb.sv
// Combinational stall priority encoder: the deepest requesting stage wins and
// a bubble is pushed into the register just past the stalled region.
module pipe_ctrl_stall_arb import pipe_ctrl_pkg::*; (
  input  logic               id_stallreq,
  input  logic               ex_stallreq,
  input  logic               ls_stallreq,
  output logic [STAGE_W-1:0] stall,
  output logic [STAGE_W-1:0] flush,
  output logic               any_stall
);

  always_comb begin
    stall = '0;
    flush = '0;
    if (ls_stallreq) begin
      stall = '1;
    end else if (ex_stallreq) begin
      stall              = hold_upto(STAGE_EX_LS);
      flush[STAGE_LS_WB] = 1'b1;
    end else if (id_stallreq) begin
      stall              = hold_upto(STAGE_ID_EX);
      flush[STAGE_EX_LS] = 1'b1;
    end
  end

  assign any_stall = id_stallreq | ex_stallreq | ls_stallreq;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall arbitration, decode-jump redirect and the
// ecall/ebreak/mret trap sequencer that owns the priority CSR write port.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter logic [REG_W-1:0] RESET_PC     = 32'h0000_0000,
  parameter logic [REG_W-1:0] MCAUSE_ECALL = 32'd11,
  parameter logic [REG_W-1:0] MCAUSE_EBRK  = 32'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  logic [STAGE_W-1:0] arb_stall;
  logic [STAGE_W-1:0] arb_flush;
  logic               ext_stall;

  pipe_ctrl_stall_arb u_stall_arb (
    .id_stallreq (bus.id_stallreq_i),
    .ex_stallreq (bus.ex_stallreq_i),
    .ls_stallreq (bus.ls_stallreq_i),
    .stall       (arb_stall),
    .flush       (arb_flush),
    .any_stall   (ext_stall)
  );

  trap_state_e      state;
  logic [REG_W-1:0] trap_pc;
  logic [REG_W-1:0] trap_cause;
  logic             is_idle;
  logic             trap_insn;
  logic             take_trap;
  logic             take_mret;

  assign is_idle   = (state == IDLE);
  assign trap_insn = bus.id_ecall_i | bus.id_ebreak_i;
  assign take_trap = is_idle & ~ext_stall & trap_insn;
  assign take_mret = is_idle & ~ext_stall & bus.id_mret_i & ~trap_insn;

  // Every non-idle state only advances on a stall-free cycle, so a CSR write
  // or redirect is issued exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trap_pc    <= '0;
      trap_cause <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take_trap) begin
            state      <= T_MEPC;
            trap_pc    <= bus.id_pc_i;
            trap_cause <= bus.id_ecall_i ? MCAUSE_ECALL : MCAUSE_EBRK;
          end else if (take_mret) begin
            state <= R_JUMP;
          end
        end
        T_MEPC:  if (!ext_stall) state <= T_CAUSE;
        T_CAUSE: if (!ext_stall) state <= T_JUMP;
        T_JUMP:  if (!ext_stall) state <= IDLE;
        R_JUMP:  if (!ext_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [STAGE_W-1:0] stall;
  logic [STAGE_W-1:0] flush;
  logic               jump_req;
  logic [REG_W-1:0]   jump_pc;
  logic               csr_we;
  logic [CSR_AW-1:0]  csr_waddr;
  logic [REG_W-1:0]   csr_wdata;

  // External stalls override the trap hold pattern; the sequencer simply waits.
  always_comb begin
    stall     = '0;
    flush     = '0;
    jump_req  = 1'b0;
    jump_pc   = '0;
    csr_we    = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    if (ext_stall) begin
      stall = arb_stall;
      flush = arb_flush;
    end else if (!is_idle) begin
      stall              = hold_upto(STAGE_IF_ID);
      flush[STAGE_ID_EX] = 1'b1;
    end
    if (!ext_stall) begin
      unique case (state)
        IDLE: begin
          if (bus.id_jump_req_i && !trap_insn && !bus.id_mret_i) begin
            jump_req           = 1'b1;
            jump_pc            = bus.id_jump_pc_i;
            flush[STAGE_IF_ID] = 1'b1;
          end
        end
        T_MEPC: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MEPC;
          csr_wdata = trap_pc;
        end
        T_CAUSE: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MCAUSE;
          csr_wdata = trap_cause;
        end
        T_JUMP: begin
          jump_req = 1'b1;
          jump_pc  = (bus.csr_mtvec_i == '0) ? RESET_PC : bus.csr_mtvec_i;
        end
        R_JUMP: begin
          jump_req = 1'b1;
          jump_pc  = bus.csr_mepc_i;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.jump_req_o  = jump_req;
  assign bus.jump_pc_o   = jump_pc;
  assign bus.csr_we_o    = csr_we;
  assign bus.csr_waddr_o = csr_waddr;
  assign bus.csr_wdata_o = csr_wdata;
  assign bus.trap_busy_o = ~is_idle;
  assign bus.trap_state  = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed trap/jump/stall scenarios followed
// by random traffic, compared against a queue-of-pending-actions reference model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [1:0]  K_CSR    = 2'd1;
  localparam logic [1:0]  K_MTVEC  = 2'd2;
  localparam logic [1:0]  K_MEPC   = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Pending trap actions: {kind[1:0], csr_addr[11:0], data[31:0]}, one per stall-free cycle.
  logic [45:0] exp_q[$];

  pipe_ctrl_if bus();

  pipe_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [4:0] s, input logic [4:0] f,
                               input logic jr, input logic [31:0] jpc, input logic we,
                               input logic [11:0] wa, input logic [31:0] wd, input logic busy);
    check({tag, ".stall"},  32'(bus.stall_o),     32'(s));
    check({tag, ".flush"},  32'(bus.flush_o),     32'(f));
    check({tag, ".jreq"},   32'(bus.jump_req_o),  32'(jr));
    check({tag, ".jpc"},    bus.jump_pc_o,        jpc);
    check({tag, ".we"},     32'(bus.csr_we_o),    32'(we));
    check({tag, ".waddr"},  32'(bus.csr_waddr_o), 32'(wa));
    check({tag, ".wdata"},  bus.csr_wdata_o,      wd);
    check({tag, ".busy"},   32'(bus.trap_busy_o), 32'(busy));
  endtask

  task automatic clear_in();
    bus.id_stallreq_i = 1'b0;
    bus.ex_stallreq_i = 1'b0;
    bus.ls_stallreq_i = 1'b0;
    bus.id_jump_req_i = 1'b0;
    bus.id_jump_pc_i  = '0;
    bus.id_pc_i       = '0;
    bus.id_ecall_i    = 1'b0;
    bus.id_ebreak_i   = 1'b0;
    bus.id_mret_i     = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; checks, advances the model,
  // and returns at the next negedge.
  task automatic cycle(input string tag);
    logic        ext, busy, jr, we;
    logic [4:0]  s, f;
    logic [31:0] jpc, wd;
    logic [11:0] wa;
    logic [45:0] head;
    #1;
    ext  = bus.ls_stallreq_i | bus.ex_stallreq_i | bus.id_stallreq_i;
    busy = (exp_q.size() != 0);
    s = '0; f = '0; jr = 1'b0; jpc = '0; we = 1'b0; wa = '0; wd = '0;
    if (bus.ls_stallreq_i)      s = 5'b11111;
    else if (bus.ex_stallreq_i) begin s = 5'b01111; f = 5'b10000; end
    else if (bus.id_stallreq_i) begin s = 5'b00111; f = 5'b01000; end
    else if (busy)              begin s = 5'b00011; f = 5'b00100; end
    if (busy && !ext) begin
      head = exp_q[0];
      case (head[45:44])
        K_CSR:   begin we = 1'b1; wa = head[43:32]; wd = head[31:0]; end
        K_MTVEC: begin jr = 1'b1; jpc = (bus.csr_mtvec_i == 0) ? RESET_PC : bus.csr_mtvec_i; end
        default: begin jr = 1'b1; jpc = bus.csr_mepc_i; end
      endcase
      void'(exp_q.pop_front());
    end else if (!busy && !ext) begin
      if (bus.id_ecall_i || bus.id_ebreak_i) begin
        exp_q.push_back({K_CSR, 12'h341, bus.id_pc_i});
        exp_q.push_back({K_CSR, 12'h342, bus.id_ecall_i ? 32'd11 : 32'd3});
        exp_q.push_back({K_MTVEC, 12'h000, 32'h0});
      end else if (bus.id_mret_i) begin
        exp_q.push_back({K_MEPC, 12'h000, 32'h0});
      end else if (bus.id_jump_req_i) begin
        jr = 1'b1; jpc = bus.id_jump_pc_i; f[1] = 1'b1;
      end
    end
    check_outputs(tag, s, f, jr, jpc, we, wa, wd, busy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clear_in();
    bus.csr_mtvec_i = '0;
    bus.csr_mepc_i  = '0;
    #2;
    check_outputs("reset", '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All three stall requests together, with a jump that must be suppressed.
    bus.ls_stallreq_i = 1'b1; bus.ex_stallreq_i = 1'b1; bus.id_stallreq_i = 1'b1;
    bus.id_jump_req_i = 1'b1; bus.id_jump_pc_i = 32'h80;
    cycle("all_stall");
    clear_in();
    bus.ex_stallreq_i = 1'b1; bus.id_stallreq_i = 1'b1;
    cycle("ex_stall");
    clear_in();
    bus.id_stallreq_i = 1'b1;
    cycle("id_stall");
    clear_in();

    bus.id_jump_req_i = 1'b1; bus.id_jump_pc_i = 32'h80;
    cycle("jump");
    clear_in();

    // ecall at 0x100 with a competing decode jump; mtvec 0x200.
    bus.csr_mtvec_i = 32'h200;
    bus.id_ecall_i = 1'b1; bus.id_pc_i = 32'h100;
    bus.id_jump_req_i = 1'b1; bus.id_jump_pc_i = 32'h444;
    cycle("ecall_det");
    clear_in();
    cycle("ecall_c1");
    bus.id_jump_req_i = 1'b1; bus.id_jump_pc_i = 32'h555;
    cycle("ecall_c2");
    clear_in();
    cycle("ecall_c3");
    cycle("ecall_c4");

    // ebreak with a 2-cycle ls stall while the mcause write is pending.
    bus.id_ebreak_i = 1'b1; bus.id_pc_i = 32'h300;
    cycle("ebrk_det");
    clear_in();
    cycle("ebrk_c1");
    bus.ls_stallreq_i = 1'b1;
    cycle("ebrk_st1");
    cycle("ebrk_st2");
    clear_in();
    cycle("ebrk_c2");
    cycle("ebrk_c3");
    cycle("ebrk_idle");

    bus.csr_mepc_i = 32'h104;
    bus.id_mret_i = 1'b1;
    cycle("mret_det");
    clear_in();
    cycle("mret_jump");
    cycle("mret_idle");

    // ecall+ebreak together with mtvec 0 falls back to RESET_PC.
    bus.csr_mtvec_i = 32'h0;
    bus.id_ecall_i = 1'b1; bus.id_ebreak_i = 1'b1; bus.id_pc_i = 32'h2c;
    cycle("both_det");
    clear_in();
    repeat (4) cycle("both_seq");

    // Asynchronous reset while the mcause write is pending.
    bus.csr_mtvec_i = 32'h600;
    bus.id_ecall_i = 1'b1; bus.id_pc_i = 32'h500;
    cycle("mid_det");
    clear_in();
    cycle("mid_c1");
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("mid_rst", '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst0");
    cycle("post_rst1");

    for (int i = 0; i < 3000; i++) begin
      bus.ls_stallreq_i = ($urandom_range(0, 11) == 0);
      bus.ex_stallreq_i = ($urandom_range(0, 9) == 0);
      bus.id_stallreq_i = ($urandom_range(0, 7) == 0);
      bus.id_jump_req_i = ($urandom_range(0, 2) == 0);
      bus.id_jump_pc_i  = $urandom;
      bus.id_pc_i       = $urandom;
      bus.id_ecall_i    = ($urandom_range(0, 15) == 0);
      bus.id_ebreak_i   = ($urandom_range(0, 15) == 0);
      bus.id_mret_i     = ($urandom_range(0, 15) == 0);
      bus.csr_mtvec_i   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      bus.csr_mepc_i    = $urandom;
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
